// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {instr, pc, pc_4}
// tuples with valid/ready on both sides and a whole-queue mispredict flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_4,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_4,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 * XLEN;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, empty;
  logic [ENT_W-1:0] head;

  assign empty     = (count_q == '0);
  // in_ready deliberately ignores out_ready: one bubble when full, no comb path
  assign in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_instr = empty ? '0 : head[ENT_W-1 -: XLEN];
  assign out_pc    = empty ? '0 : head[2*XLEN-1 -: XLEN];
  assign out_pc_4  = empty ? '0 : head[XLEN-1:0];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_instr, in_pc, in_pc_4};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(pop && empty));
  a_out_stable: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !flush) |=>
      ($stable(out_instr) && $stable(out_pc) && $stable(out_pc_4)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [XLEN-1:0]  in_instr = '0, in_pc = '0, in_pc_4 = '0;
  logic             in_ready, out_valid;
  logic [XLEN-1:0]  out_instr, out_pc, out_pc_4;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_4(in_pc_4), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_4(out_pc_4), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ir, e_ov;
    int          e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA0 + (pc >> 2);
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] p4, input logic ordy);
    reset = rst; flush = fl; in_valid = iv;
    in_instr = ins; in_pc = p; in_pc_4 = p4; out_ready = ordy;
  endtask

  // Reference model: acceptance decided from occupancy and current inputs only.
  logic m_ir, m_ov;
  task automatic model_eval();
    m_ir = !flush && (mq.size() < DEPTH);
    m_ov = !flush && (mq.size() != 0);
  endtask

  task automatic model_check(input string tag);
    model_eval();
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk({tag, ".out_instr"}, out_instr, mq[0].instr);
      chk({tag, ".out_pc"}, out_pc, mq[0].pc);
      chk({tag, ".out_pc_4"}, out_pc_4, mq[0].pc4);
    end else begin
      chk({tag, ".out_pc_empty"}, out_pc, 32'h0);
    end
  endtask

  task automatic model_step();
    logic do_push, do_pop;
    ent_t e;
    model_eval();
    do_push = in_valid && m_ir;
    do_pop  = out_ready && m_ov;
    if (!reset || flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.instr = in_instr; e.pc = in_pc; e.pc4 = in_pc_4;
        mq.push_back(e);
      end
    end
  endtask

  // One model-checked clock: drive, settle, compare, clock, advance model.
  task automatic cyc(input string tag, input logic rst, input logic fl,
                     input logic iv, input logic [31:0] p, input logic ordy);
    drive(rst, fl, iv, instr_of(p), p, p + 32'd4, ordy);
    #1;
    if (rst) model_check(tag);
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  vec_t vt[19];
  int   pidx;
  logic [31:0] p;

  initial begin
    // rst fl iv pc ordy | in_ready out_valid count out_pc
    vt[0]  = '{1,0,1,32'h00,1, 1,0,0,32'h00};
    vt[1]  = '{1,0,1,32'h04,1, 1,1,1,32'h00};
    vt[2]  = '{1,0,1,32'h08,1, 1,1,1,32'h04};
    vt[3]  = '{1,0,0,32'h00,1, 1,1,1,32'h08};
    vt[4]  = '{1,0,0,32'h00,0, 1,0,0,32'h00};
    vt[5]  = '{1,0,1,32'h00,0, 1,0,0,32'h00};
    vt[6]  = '{1,0,1,32'h04,0, 1,1,1,32'h00};
    vt[7]  = '{1,0,1,32'h08,0, 1,1,2,32'h00};
    vt[8]  = '{1,1,1,32'h40,1, 0,0,3,32'h00};
    vt[9]  = '{1,0,1,32'h40,0, 1,0,0,32'h00};
    vt[10] = '{1,0,0,32'h00,0, 1,1,1,32'h40};
    vt[11] = '{1,0,0,32'h00,1, 1,1,1,32'h40};
    vt[12] = '{1,0,0,32'h00,0, 1,0,0,32'h00};
    vt[13] = '{1,0,1,32'h80,0, 1,0,0,32'h00};
    vt[14] = '{1,0,1,32'h84,0, 1,1,1,32'h80};
    vt[15] = '{1,0,1,32'h88,0, 1,1,2,32'h80};
    vt[16] = '{0,0,1,32'h8C,1, 1,1,3,32'h80};
    vt[17] = '{1,0,0,32'h00,1, 1,0,0,32'h00};
    vt[18] = '{1,0,0,32'h00,0, 1,0,0,32'h00};

    // Two reset cycles with the bench aligned to 1 time unit after posedge.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    @(posedge clk); model_step(); #1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].fl, vt[i].iv, instr_of(vt[i].pc), vt[i].pc,
            vt[i].pc + 32'd4, vt[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d.out_pc", i), out_pc, vt[i].e_pc);
      chk($sformatf("vec%0d.out_instr", i), out_instr,
          (vt[i].e_cnt != 0) ? instr_of(vt[i].e_pc) : 32'h0);
      chk($sformatf("vec%0d.out_pc_4", i), out_pc_4,
          (vt[i].e_cnt != 0) ? vt[i].e_pc + 32'd4 : 32'h0);
      @(posedge clk);
      model_step();
      #1;
    end

    // Fill and backpressure: offer 0x0..0x10 with decode stalled.
    pidx = 0;
    for (int i = 0; i < 6; i++) begin
      p = 32'(pidx * 4);
      cyc("fill", 1, 0, 1, p, 0);
      if (in_valid && m_ir) pidx++;
    end
    drive(1, 0, 1, instr_of(32'h10), 32'h10, 32'h14, 0); #1;
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.held_idx", 32'(pidx), 32'd4);
    cyc("full_pop", 1, 0, 1, 32'h10, 1);
    drive(1, 0, 1, instr_of(32'h10), 32'h10, 32'h14, 0); #1;
    chk("after_pop.count", 32'(count), 32'd3);
    chk("after_pop.in_ready", 32'(in_ready), 32'd1);
    chk("after_pop.head", out_pc, 32'h04);
    cyc("accept10", 1, 0, 1, 32'h10, 0);
    for (int i = 0; i < 6; i++) cyc("drain", 1, 0, 0, 0, 1);
    chk("drained", 32'(mq.size()), 32'd0);

    // Wrap-around: ten pcs with out_ready toggling, bounded cycle budget.
    pidx = 0;
    for (int i = 0; i < 40 && (pidx < 10 || mq.size() != 0); i++) begin
      p = 32'(pidx * 4);
      cyc("wrap", 1, 0, (pidx < 10), p, i[0]);
      if (in_valid && m_ir) pidx++;
    end
    chk("wrap.all_pushed", 32'(pidx), 32'd10);
    chk("wrap.empty", 32'(count), 32'd0);

    // Simultaneous push/pop at count 2.
    cyc("sim_fill", 1, 0, 1, 32'h100, 0);
    cyc("sim_fill", 1, 0, 1, 32'h104, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("sim_pp", 1, 0, 1, 32'h108 + 32'(i * 4), 1);
      chk("sim_pp.count", 32'(count), 32'd2);
    end
    chk("sim_pp.head", out_pc, 32'h10C);

    // Randomized traffic including occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch unit and decode.
- Accepts {instr, pc, pc_4} tuples from fetch through a valid/ready handshake, stores them in a circular FIFO, and presents them in order to decode.
- Drives the fetch unit's ready_out so that decode stalls push back on fetch.
- Flushes completely on branch mispredict so that no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, 32, width of instr, pc and pc_4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  mispredict flush; discards all entries.
- in_valid  input  1  fetch presents a valid tuple.
- in_instr  input  XLEN  instruction word from fetch.
- in_pc  input  XLEN  PC of in_instr.
- in_pc_4  input  XLEN  in_pc + 4, as supplied by fetch.
- in_ready  output  1  queue can accept; connects to the fetch unit's ready_out.
- out_valid  output  1  head entry is valid for decode.
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  head PC.
- out_pc_4  output  XLEN  head pc_4.
- out_ready  input  1  decode accepts the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - storage array of DEPTH x 3*XLEN;
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register.
- Reset (reset==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Storage contents are don't-care.
  - Resulting outputs: out_valid=0, in_ready=1, count=0.
  - out_instr, out_pc and out_pc_4 read 0 while empty.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush.
  - Depends only on registered state and flush; no combinational path from out_ready. This is deliberate and accepted: it costs one bubble when full.
- out_valid = (count != 0) && !flush.
- out_* are driven combinationally from storage[rd_ptr]; they read 0 when count==0.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass, so an empty queue with in_valid=1 shows out_valid=0 in that cycle.
- Push at posedge: write storage[wr_ptr] and increment wr_ptr (wraps DEPTH-1 -> 0).
- Pop at posedge: increment rd_ptr (wraps).
- Count update: push only, +1; pop only, -1; both, unchanged; neither, unchanged.
- Full (count==DEPTH):
  - in_ready=0; fetch holds its tuple.
  - A pop in this cycle frees a slot; in_ready rises the following cycle.
- Empty (count==0): out_valid=0; out_ready is ignored.
- Flush (flush==1 at posedge, reset==1):
  - wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in that cycle is discarded.
  - In the flush cycle itself, in_ready=0 and out_valid=0.
  - The first post-flush tuple (the redirect target) is accepted in the cycle after flush deasserts.
- Priority: reset > flush > push/pop.
- Reset during an operation:
  - Discards all entries regardless of flush, in_valid and out_ready.
  - Outputs meet the reset values after that edge.
- Order: FIFO order is strict. The queue never reorders, duplicates or modifies payload; pc_4 passes through as supplied and is not recomputed.
- Assertions (simulation only):
  - count never exceeds DEPTH;
  - no pop when count==0;
  - out_* stable while out_valid && !out_ready && !flush.

Test Plan:
- Reset and basic pass-through:
  - Stimulus: hold reset=0 for 2 cycles, then release. Push pc 0x0/0x4/0x8 (instr 0xA0,0xA1,0xA2) with out_ready=1.
  - Response: out_valid first high one cycle after the first push; decode sees PC 0x0, 0x4, 0x8 in order with pc_4 = 0x4, 0x8, 0xC; count never exceeds 1.
- Fill and backpressure:
  - Stimulus: out_ready=0 with continuous pushes of pc 0x0..0x10.
  - Response: count reaches 4; in_ready=0 with pc 0x10 held unaccepted.
  - Stimulus: raise out_ready for 1 cycle.
  - Response: head 0x0 pops; count=3; in_ready=1 next cycle; 0x10 is then accepted as the last entry.
- Wrap-around:
  - Stimulus: 10 pushes (pc 0x0..0x24) with out_ready toggling every cycle.
  - Response: all 10 PCs emerge in order with no loss or duplication after the pointers wrap twice.
- Mispredict flush:
  - Stimulus: queue holds pc 0x0, 0x4, 0x8. Assert flush=1 for one cycle with in_valid=1, pc=0x40.
  - Response: count=0 after the edge; 0x40 not captured in the flush cycle; in_ready=0 and out_valid=0 during flush.
  - Stimulus: next cycle, push pc=0x40.
  - Response: out_pc=0x40, pc_4=0x44 appears one cycle later.
- Simultaneous push and pop:
  - Stimulus: count=2, in_valid=1 and out_ready=1 for 3 cycles.
  - Response: count stays 2; output order is continuous.
- Reset mid-stream:
  - Stimulus: count=3, reset=0 with flush=0 and in_valid=1.
  - Response: count=0, out_valid=0, in_ready=1 after the edge; no stale entry appears afterwards.
